// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Initiator-side sequencer for the CPU controller start/waiting handshake.
//   Holds a loadable program memory of 16-bit instructions, presents one at a
//   time on instr_o, pulses start_o, tracks waiting_i through acceptance and
//   completion, then advances the PC. Opcode 3'b111 is HALT and is never issued.
//
//   State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for go_i; program memory writable
//   S_FETCH | one cycle; latch mem[pc] into instr, decode HALT
//   S_ISSUE | start_o high, waiting for controller to drop waiting_i
//   S_EXEC  | start_o low, waiting for controller to raise waiting_i
//   S_HALT  | program finished (HALT opcode or last address); done_o high
//   S_ERR   | handshake timeout; err_o high, pc/instr hold faulting values
//
// Ports
//   clk_i, rst_ni     clock (rising edge), async active-low reset
//   go_i              start execution at address 0 (from IDLE/HALT/ERR)
//   abort_i           force IDLE on next edge, priority over everything
//   prog_we_i/addr/wdata  program memory write port (ignored while busy)
//   waiting_i         controller idle indication (1 = idle/done)
//   instr_o, pc_o     current instruction and its address
//   start_o           registered request to the controller
//   busy_o/done_o/err_o  decoded from the state register
//   retired_o         completed instruction count, saturating at 255
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  input  logic          abort_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [15:0]   prog_wdata_i,
  input  logic          waiting_i,
  output logic [15:0]   instr_o,
  output logic          start_o,
  output logic [AW-1:0] pc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [7:0]    retired_o
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
  localparam logic [2:0]    OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic          start_q, start_d;
  logic [7:0]    retired_q, retired_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   fetched;
  logic          mem_we;

  // Program memory: no reset, writable only when not executing.
  assign mem_we  = prog_we_i &&
                   ((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));
  assign fetched = mem_q[pc_q];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[prog_addr_i] <= prog_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= 16'h0000;
      start_q   <= 1'b0;
      retired_q <= 8'd0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      start_q   <= start_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    start_d   = start_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;

    if (abort_i) begin
      // pc, instr and retired deliberately hold so the host can inspect them.
      state_d = S_IDLE;
      start_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT, S_ERR: begin
          if (go_i) begin
            pc_d      = '0;
            retired_d = 8'd0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH: begin
          instr_d = fetched;
          tmo_d   = '0;
          if (fetched[15:13] == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            state_d = S_ISSUE;
            start_d = 1'b1;
          end
        end
        S_ISSUE: begin
          // Acceptance is waiting_i going low; a stale high is never completion.
          if (!waiting_i) begin
            state_d = S_EXEC;
            start_d = 1'b0;
            tmo_d   = '0;
          end else if (tmo_q == TMO_MAX) begin
            state_d = S_ERR;
            start_d = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_EXEC: begin
          if (waiting_i) begin
            if (retired_q != 8'hFF) begin
              retired_d = retired_q + 8'd1;
            end
            if (pc_q == PC_LAST) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = S_FETCH;
            end
          end else if (tmo_q == TMO_MAX) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          start_d = 1'b0;
        end
      endcase
    end
  end

  assign instr_o   = instr_q;
  assign start_o   = start_q;
  assign pc_o      = pc_q;
  assign retired_o = retired_q;
  assign busy_o    = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign done_o    = (state_q == S_HALT);
  assign err_o     = (state_q == S_ERR);

endmodule
